// File: rtl/contador_seq.sv
`default_nettype none
// ============================================================================
//  Module   : contador_seq
//  Purpose  : Command-driven sequencer around a bouncing up/down counter.
//             A requester programs lo, hi and a trip count through a
//             valid/ready handshake. The counter then runs lo -> hi -> lo
//             for the requested number of trips and pulses done. A trip
//             count of zero runs until aborted.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       clock, rising edge
//    rst        in   1       asynchronous, active-high reset
//    cmd_valid  in   1       command present
//    cmd_ready  out  1       command can be accepted (IDLE only)
//    cmd_lo     in   WIDTH   lower bound
//    cmd_hi     in   WIDTH   upper bound (must be > cmd_lo)
//    cmd_trips  in   TRIP_W  trip count, 0 = run until abort
//    abort      in   1       stop the current run, no done pulse
//    pause      in   1       freeze the run (CONTADOR_PAUSE_EN builds only)
//    s          out  WIDTH   counter value
//    dir        out  1       0 = counting up, 1 = counting down
//    busy       out  1       run in progress
//    done       out  1       one-cycle pulse on normal completion
//    err        out  1       one-cycle pulse on a rejected command
// ----------------------------------------------------------------------------
//  Build option
//    CONTADOR_PAUSE_EN : when defined, pause=1 in UP/DOWN freezes the run.
//                        When undefined, pause is ignored.
// ============================================================================
module contador_seq #(
    parameter int WIDTH  = 4,
    parameter int TRIP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_lo,
    input  logic [WIDTH-1:0]  cmd_hi,
    input  logic [TRIP_W-1:0] cmd_trips,
    input  logic              abort,
    input  logic              pause,
    output logic [WIDTH-1:0]  s,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [WIDTH-1:0]  C_ONE_S    = WIDTH'(1);
    localparam logic [TRIP_W-1:0] C_ONE_TRIP = TRIP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    state_t             r_state,      w_state;
    logic [WIDTH-1:0]   r_s,          w_s;
    logic               r_dir,        w_dir;
    logic               r_busy,       w_busy;
    logic               r_done,       w_done;
    logic               r_err,        w_err;
    logic               r_ready,      w_ready;
    logic [WIDTH-1:0]   r_lo,         w_lo;
    logic [WIDTH-1:0]   r_hi,         w_hi;
    logic [TRIP_W-1:0]  r_trips,      w_trips;
    logic [TRIP_W-1:0]  r_trips_done, w_trips_done;

    logic               w_pause;
    logic [TRIP_W-1:0]  w_trip_inc;
    logic               w_last_trip;

`ifdef CONTADOR_PAUSE_EN
    assign w_pause = pause;
`else
    // Pause is not part of this build; tie it off so the run never freezes.
    logic w_unused_pause;
    assign w_unused_pause = pause;
    assign w_pause        = 1'b0;
`endif

    // Trip number that is finishing when the counter reaches lo in DOWN.
    assign w_trip_inc  = r_trips_done + C_ONE_TRIP;
    assign w_last_trip = (r_trips != '0) && (w_trip_inc == r_trips);

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state      = r_state;
        w_s          = r_s;
        w_dir        = r_dir;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_ready      = r_ready;
        w_lo         = r_lo;
        w_hi         = r_hi;
        w_trips      = r_trips;
        w_trips_done = r_trips_done;

        case (r_state)
            ST_IDLE: begin
                w_dir   = 1'b0;
                w_busy  = 1'b0;
                w_ready = 1'b1;
                // abort is meaningless here, so a command is still accepted.
                if (cmd_valid && r_ready) begin
                    if (cmd_lo >= cmd_hi) begin
                        w_err = 1'b1;
                    end else begin
                        w_state      = ST_UP;
                        w_s          = cmd_lo;
                        w_busy       = 1'b1;
                        w_ready      = 1'b0;
                        w_lo         = cmd_lo;
                        w_hi         = cmd_hi;
                        w_trips      = cmd_trips;
                        w_trips_done = '0;
                    end
                end
            end

            ST_UP: begin
                if (abort) begin
                    w_state = ST_IDLE;
                    w_busy  = 1'b0;
                    w_dir   = 1'b0;
                    w_ready = 1'b1;
                end else if (!w_pause) begin
                    if (r_s == r_hi) begin
                        // hi is shown exactly once; turn around immediately.
                        w_s     = r_hi - C_ONE_S;
                        w_dir   = 1'b1;
                        w_state = ST_DOWN;
                    end else begin
                        w_s = r_s + C_ONE_S;
                    end
                end
            end

            ST_DOWN: begin
                // abort has priority, including over a final completion.
                if (abort) begin
                    w_state = ST_IDLE;
                    w_busy  = 1'b0;
                    w_dir   = 1'b0;
                    w_ready = 1'b1;
                end else if (!w_pause) begin
                    if (r_s == r_lo) begin
                        if (w_last_trip) begin
                            w_state = ST_IDLE;
                            w_busy  = 1'b0;
                            w_dir   = 1'b0;
                            w_ready = 1'b1;
                            w_done  = 1'b1;
                        end else begin
                            // lo was already shown; next trip starts at lo+1.
                            w_s     = r_lo + C_ONE_S;
                            w_dir   = 1'b0;
                            w_state = ST_UP;
                            // Endless runs saturate the trip counter.
                            if (!((r_trips == '0) && (&r_trips_done))) begin
                                w_trips_done = w_trip_inc;
                            end
                        end
                    end else begin
                        w_s = r_s - C_ONE_S;
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
                w_dir   = 1'b0;
                w_ready = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_dir        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ready      <= 1'b1;
            r_lo         <= '0;
            r_hi         <= '0;
            r_trips      <= '0;
            r_trips_done <= '0;
        end else begin
            r_state      <= w_state;
            r_s          <= w_s;
            r_dir        <= w_dir;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_err        <= w_err;
            r_ready      <= w_ready;
            r_lo         <= w_lo;
            r_hi         <= w_hi;
            r_trips      <= w_trips;
            r_trips_done <= w_trips_done;
        end
    end

    assign s         = r_s;
    assign dir       = r_dir;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign cmd_ready = r_ready;

endmodule
`default_nettype wire
